// File: rtl/match_pkg.sv
// Shared definitions for the match window counter: state encoding and default sizing.
package match_pkg;

  localparam int unsigned CNT_W_DEFAULT  = 8;
  localparam int unsigned WINDOW_DEFAULT = 256;
  localparam int unsigned WIN_CNT_W      = 16;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_COUNT = 1'b1;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StCount = ST_COUNT
  } state_e;

endpackage

// File: rtl/match_window_counter_if.sv
// Result port of the match window counter: one-deep valid/ready register plus sticky overrun.
interface match_window_counter_if
  import match_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
);

  logic [CNT_W-1:0] count_out;
  logic             count_sat;
  logic             count_valid;
  logic             count_ready;
  logic             overrun;

  modport master (
    output count_out,
    output count_sat,
    output count_valid,
    output overrun,
    input  count_ready
  );

  modport slave (
    input  count_out,
    input  count_sat,
    input  count_valid,
    input  overrun,
    output count_ready
  );

endinterface

// File: rtl/sat_accumulator.sv
// Per-window saturating match accumulator; sat records that at least one increment was clamped.
module sat_accumulator
  import match_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] acc,
  output logic             sat
);

  logic [CNT_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [CNT_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {{CNT_W{1'b0}}, inc};
    acc_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    sat_d = sat_q | sum[CNT_W];
    if (clr) begin
      acc_d = '0;
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign acc = acc_q;
  assign sat = sat_q;

endmodule

// File: rtl/match_window_counter.sv
// Counts detector match pulses over fixed WINDOW-cycle windows and hands each window's count
// to a one-deep valid/ready result register, flagging saturation and unconsumed overwrites.
module match_window_counter
  import match_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEFAULT,
  parameter int unsigned WINDOW = WINDOW_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  match_in,
  input  logic                  enable,
  match_window_counter_if.master cnt_if
);

  localparam logic [WIN_CNT_W-1:0] LastIdx = WIN_CNT_W'(WINDOW - 1);

  state_e               state_q, state_d;
  logic [WIN_CNT_W-1:0] win_q, win_d;
  logic                 counting;
  logic                 last;
  logic                 clr;
  logic [CNT_W-1:0]     acc;
  logic                 acc_sat;
  logic [CNT_W:0]       fin_sum;

  logic [CNT_W-1:0]     out_q, out_d;
  logic                 osat_q, osat_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;

  assign counting = (state_q == StCount);
  assign last     = counting && (win_q == LastIdx);
  // The accumulator only keeps running inside a window that continues past this cycle.
  assign clr      = !(counting && enable && !last);

  sat_accumulator #(
    .CNT_W (CNT_W)
  ) u_acc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .inc     (match_in & counting),
    .acc     (acc),
    .sat     (acc_sat)
  );

  // Final-cycle sample is folded in here since the accumulator clears on that edge.
  assign fin_sum = {1'b0, acc} + {{CNT_W{1'b0}}, match_in};

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (enable) state_d = StCount;
      StCount: if (!enable) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    win_d = clr ? '0 : win_q + 1'b1;
  end

  always_comb begin
    out_d   = out_q;
    osat_d  = osat_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (last) begin
      out_d   = fin_sum[CNT_W] ? '1 : fin_sum[CNT_W-1:0];
      osat_d  = acc_sat | fin_sum[CNT_W];
      valid_d = 1'b1;
      if (valid_q && !cnt_if.count_ready) ovr_d = 1'b1;
    end else if (valid_q && cnt_if.count_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      win_q   <= '0;
      out_q   <= '0;
      osat_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      out_q   <= out_d;
      osat_q  <= osat_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign cnt_if.count_out   = out_q;
  assign cnt_if.count_sat   = osat_q;
  assign cnt_if.count_valid = valid_q;
  assign cnt_if.overrun     = ovr_q;

endmodule
